// File: rtl/tc_irq_ctrl.sv
// Interrupt controller for two timer/counter blocks: latches flag pulses into
// a pending register, masks them and offers one fixed-priority vector to the CPU.
//
// state   | meaning
// IDLE    | no request outstanding, arbitrating pending & mask
// REQ     | vector offered to the CPU, waiting for ack (or withdrawal)
// SERVICE | handler running, waiting for irq_done
module tc_irq_ctrl #(
    parameter int          NUM_SRC   = 6,
    parameter logic [7:0]  MASK_ADDR = 8'h6F,
    parameter logic [7:0]  PEND_ADDR = 8'h36
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_flag,
    input  logic               status_reg_interrupt_enable,
    input  logic               write,
    input  logic               read,
    input  logic [7:0]         addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               interrupt_request,
    output logic [2:0]         irq_vector,
    output logic               in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] pending, pending_nxt;
    logic [NUM_SRC-1:0] mask, mask_nxt;
    logic [NUM_SRC-1:0] clr, active;
    logic [2:0]         vec_nxt, lowest;
    logic               ack_fire, offer_ok;
    logic               wr_mask, wr_pend;
    logic               unused_wdata;

    assign unused_wdata = &{1'b0, wdata};

    assign wr_mask  = write && (addr == MASK_ADDR);
    assign wr_pend  = write && (addr == PEND_ADDR);
    assign ack_fire = (state == REQ) && irq_ack;
    assign active   = pending & mask;

    always_comb begin
        clr = '0;
        if (wr_pend)
            clr = wdata[NUM_SRC-1:0];
        if (ack_fire)
            clr[irq_vector] = 1'b1;
    end

    // Set beats clear: a flag pulse in the same cycle survives W1C and ack.
    assign pending_nxt = (pending & ~clr) | src_flag;
    assign mask_nxt    = wr_mask ? wdata[NUM_SRC-1:0] : mask;

    // Withdrawal looks at what the offered bit will be after this edge.
    assign offer_ok = pending_nxt[irq_vector] && mask_nxt[irq_vector]
                      && status_reg_interrupt_enable;

    always_comb begin
        lowest = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i])
                lowest = 3'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = irq_vector;
        case (state)
            IDLE: begin
                if (status_reg_interrupt_enable && (active != '0)) begin
                    state_nxt = REQ;
                    vec_nxt   = lowest;
                end
            end
            REQ: begin
                if (irq_ack)
                    state_nxt = SERVICE;
                else if (!offer_ok)
                    state_nxt = IDLE;
            end
            SERVICE: begin
                if (irq_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            irq_vector <= '0;
            pending    <= '0;
            mask       <= '0;
        end else begin
            state      <= state_nxt;
            irq_vector <= vec_nxt;
            pending    <= pending_nxt;
            mask       <= mask_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (read) begin
            if (addr == MASK_ADDR)
                rdata <= 8'(mask);
            else if (addr == PEND_ADDR)
                rdata <= 8'(pending);
        end
    end

    assign interrupt_request = (state == REQ);
    assign in_service        = (state == SERVICE);

endmodule

// File: tb/tb_tc_irq_ctrl.sv
// Bench for tc_irq_ctrl: directed scenarios then random traffic, every cycle
// compared against a behavioural model of the controller.
module tb_tc_irq_ctrl;

    localparam logic [7:0] MASK_A  = 8'h6F;
    localparam logic [7:0] PEND_A  = 8'h36;
    localparam logic [7:0] OTHER_A = 8'h10;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] src_flag;
    logic       status_reg_interrupt_enable;
    logic       write, read;
    logic [7:0] addr, wdata, rdata;
    logic       irq_ack, irq_done;
    logic       interrupt_request;
    logic [2:0] irq_vector;
    logic       in_service;

    int checks = 0;
    int errors = 0;

    // model: state 0 = idle, 1 = requesting, 2 = in service
    int m_pend, m_mask, m_rdata, m_state, m_vec;

    tc_irq_ctrl dut (
        .clk                         (clk),
        .rst                         (rst),
        .src_flag                    (src_flag),
        .status_reg_interrupt_enable (status_reg_interrupt_enable),
        .write                       (write),
        .read                        (read),
        .addr                        (addr),
        .wdata                       (wdata),
        .rdata                       (rdata),
        .irq_ack                     (irq_ack),
        .irq_done                    (irq_done),
        .interrupt_request           (interrupt_request),
        .irq_vector                  (irq_vector),
        .in_service                  (in_service)
    );

    always #5 clk = ~clk;

    function automatic int lowest_bit(input int v);
        for (int i = 0; i < 6; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int clr, np, nm;
        bit keep;
        clr = 0;
        if (write && addr == PEND_A) clr = int'(wdata) & 63;
        if (m_state == 1 && irq_ack) clr = clr | (1 << m_vec);
        np = ((m_pend & ~clr) | int'(src_flag)) & 63;
        nm = (write && addr == MASK_A) ? (int'(wdata) & 63) : m_mask;
        if (read && addr == MASK_A) m_rdata = m_mask;
        else if (read && addr == PEND_A) m_rdata = m_pend;
        case (m_state)
            0: if (status_reg_interrupt_enable && (m_pend & m_mask) != 0) begin
                   m_state = 1;
                   m_vec   = lowest_bit(m_pend & m_mask);
               end
            1: begin
                   keep = ((np >> m_vec) & 1) == 1 && ((nm >> m_vec) & 1) == 1
                          && status_reg_interrupt_enable;
                   if (irq_ack) m_state = 2;
                   else if (!keep) m_state = 0;
               end
            default: if (irq_done) m_state = 0;
        endcase
        m_pend = np;
        m_mask = nm;
    endtask

    task automatic compare_all();
        check("rdata", int'(rdata), m_rdata);
        check("interrupt_request", int'(interrupt_request), (m_state == 1) ? 1 : 0);
        check("in_service", int'(in_service), (m_state == 2) ? 1 : 0);
        check("irq_vector", int'(irq_vector), m_vec);
    endtask

    task automatic clear_strobes();
        src_flag = '0; write = 0; read = 0; addr = '0; wdata = '0;
        irq_ack = 0; irq_done = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        clear_strobes();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1;
        m_pend = 0; m_mask = 0; m_rdata = 0; m_state = 0; m_vec = 0;
        #1;
        check("rst_req", int'(interrupt_request), 0);
        check("rst_svc", int'(in_service), 0);
        check("rst_vec", int'(irq_vector), 0);
        check("rst_rdata", int'(rdata), 0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        write = 1; addr = a; wdata = d;
    endtask

    task automatic rd(input logic [7:0] a);
        read = 1; addr = a;
    endtask

    initial begin
        rst = 1;
        status_reg_interrupt_enable = 1;
        clear_strobes();
        do_reset();

        // single source, vector 2, two-edge latency
        wr(MASK_A, 8'h3F); step();
        src_flag = 6'b000100; step();
        check("lat_edge1_req", int'(interrupt_request), 0);
        step();
        check("s2_req", int'(interrupt_request), 1);
        check("s2_vec", int'(irq_vector), 2);
        irq_ack = 1; step();
        check("s2_svc", int'(in_service), 1);
        rd(PEND_A); step();
        check("s2_pend", int'(rdata), 0);
        irq_done = 1; step();
        check("s2_done", int'(in_service), 0);

        // two pending, priority order 1 then 5
        src_flag = 6'b100010; step();
        step();
        check("pri_first", int'(irq_vector), 1);
        irq_ack = 1; step();
        irq_done = 1; step();
        step();
        check("pri_second_req", int'(interrupt_request), 1);
        check("pri_second", int'(irq_vector), 5);
        irq_ack = 1; step();
        irq_done = 1; step();

        // masked source pends but does not request
        wr(MASK_A, 8'h00); step();
        src_flag = 6'b000001; step();
        step(); step();
        check("masked_noreq", int'(interrupt_request), 0);
        rd(PEND_A); step();
        check("masked_pend", int'(rdata), 8'h01);
        wr(MASK_A, 8'h01); step();
        step();
        check("unmask_req", int'(interrupt_request), 1);
        check("unmask_vec", int'(irq_vector), 0);
        irq_ack = 1; step();
        irq_done = 1; step();

        // withdrawal by W1C, and set winning over clear
        wr(MASK_A, 8'h08); step();
        src_flag = 6'b001000; step();
        step();
        check("w_req", int'(irq_vector), 3);
        wr(PEND_A, 8'h08); src_flag = 6'b001000; step();
        check("w_setwins_req", int'(interrupt_request), 1);
        rd(PEND_A); step();
        check("w_setwins_pend", int'(rdata), 8'h08);
        wr(PEND_A, 8'h08); step();
        check("w_withdraw", int'(interrupt_request), 0);
        check("w_idle", int'(in_service), 0);

        // reset during service with everything pending
        wr(MASK_A, 8'h3F); step();
        src_flag = 6'h3F; step();
        step();
        irq_ack = 1; step();
        src_flag = 6'h01; step();
        check("pre_rst_svc", int'(in_service), 1);
        do_reset();
        step(); step(); step();
        check("post_rst_noreq", int'(interrupt_request), 0);
        rd(MASK_A); step();
        check("post_rst_mask", int'(rdata), 0);

        // random traffic against the model
        for (int n = 0; n < 800; n++) begin
            int r;
            status_reg_interrupt_enable = ($urandom % 8) != 0;
            if ($urandom % 4 == 0) src_flag = 6'($urandom);
            r = $urandom % 16;
            case (r)
                0, 1: wr(MASK_A, 8'($urandom));
                2, 3: wr(PEND_A, 8'($urandom));
                4:    wr(OTHER_A, 8'($urandom));
                5, 6: rd(MASK_A);
                7, 8: rd(PEND_A);
                9:    rd(OTHER_A);
                default: ;
            endcase
            irq_ack  = ($urandom % 3) == 0;
            irq_done = ($urandom % 4) == 0;
            if ($urandom % 250 == 0) begin
                clear_strobes();
                do_reset();
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tc_irq_ctrl.md
TC_IRQ_CTRL -- requirements
Module: tc_irq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 6, giving the number of interrupt sources (timer 0 OCFB/OCFA/TOV = 2/1/0, timer 1 = 5/4/3).
REQ-002 The block SHALL have parameter MASK_ADDR, default 8'h6F, giving the mask register address.
REQ-003 The block SHALL have parameter PEND_ADDR, default 8'h36, giving the pending register address.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 src_flag  in  NUM_SRC  per-source single-cycle event pulses from the timer/counter flag bits.
REQ-007 status_reg_interrupt_enable  in  1  global interrupt enable (I bit).
REQ-008 write  in  1  register write strobe.
REQ-009 read  in  1  register read strobe.
REQ-010 addr  in  8  register address.
REQ-011 wdata  in  8  write data.
REQ-012 rdata  out  8  read data.
REQ-013 irq_ack  in  1  CPU accepts the offered vector.
REQ-014 irq_done  in  1  CPU end of service (RETI).
REQ-015 interrupt_request  out  1  request to CPU.
REQ-016 irq_vector  out  3  index of the offered source.
REQ-017 in_service  out  1  high while a handler is in progress.

Function
REQ-018 pending[NUM_SRC-1:0] SHALL set bit k on any cycle src_flag[k]=1, independent of mask, enable or state.
REQ-019 A write to PEND_ADDR SHALL clear every pending bit whose wdata bit is 1 (write-1-to-clear), with 0 bits unchanged.
REQ-020 A write to MASK_ADDR SHALL load mask[NUM_SRC-1:0] from wdata[NUM_SRC-1:0], ignoring the upper bits.
REQ-021 If a set (src_flag) and a clear (W1C or ack) hit the same pending bit in the same cycle, the set SHALL win.
REQ-022 A read of MASK_ADDR or PEND_ADDR SHALL drive rdata, zero-extended to 8 bits, on the next edge.
REQ-023 A read of any other address SHALL leave rdata unchanged, and rdata SHALL otherwise hold its last value.
REQ-024 The block SHALL implement an FSM with states IDLE, REQ and SERVICE.
REQ-025 IDLE: when status_reg_interrupt_enable=1 and (pending & mask)!=0, on the next edge the FSM SHALL enter REQ, set interrupt_request=1, and load irq_vector with the lowest set index (fixed priority, index 0 highest).
REQ-026 REQ: irq_vector SHALL stay frozen, with no re-arbitration on a higher-priority arrival.
REQ-027 REQ: on irq_ack=1 the FSM SHALL clear pending[irq_vector], drop interrupt_request, set in_service=1 and go to SERVICE on the same edge.
REQ-028 REQ: if the offered bit is cleared or masked, or status_reg_interrupt_enable drops, before an ack, the FSM SHALL withdraw: interrupt_request=0 and return to IDLE on the next edge.
REQ-029 An ack arriving in the same cycle as a withdrawal condition SHALL take priority over the withdrawal.
REQ-030 SERVICE: on irq_done=1 the FSM SHALL clear in_service and return to IDLE; no nesting is supported.
REQ-031 SERVICE: new flags SHALL still accumulate in pending during service.
REQ-032 irq_ack in IDLE or SERVICE, and irq_done in IDLE or REQ, SHALL be ignored.
REQ-033 Minimum latency from a src_flag pulse to interrupt_request=1 SHALL be 2 edges (pending latch, then arbitration).

Reset
REQ-034 On rst=1 the block SHALL asynchronously force pending=0, mask=0, rdata=0, interrupt_request=0, irq_vector=0, in_service=0 and state=IDLE.
REQ-035 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the transaction, with no ack or done needed afterwards.

Verification
REQ-036 mask=6'h3F, I=1, pulse src_flag=6'b000100 -> interrupt_request=1 two edges later, irq_vector=2; ack -> pending=0, in_service=1; done -> IDLE.
REQ-037 pending=6'b100010 (mask all, I=1) -> irq_vector=1; after ack and done, irq_vector=5 is offered next.
REQ-038 mask=0, pulse src 0 -> no request and reading PEND_ADDR gives 8'h01; then write mask=8'h01 -> request with irq_vector=0.
REQ-039 In REQ with vector 3, write PEND_ADDR=8'h08 -> interrupt_request=0 next edge and state IDLE; with W1C and src_flag[3] in the same cycle, pending[3] stays 1.
REQ-040 Assert rst while in SERVICE with pending=8'h3F -> all outputs 0 immediately and mask=0, so no request after release.
